// File: rtl/fifo_checker.sv
// fifo_checker: scoreboard for a synchronous FIFO. It keeps a reference
// model of the FIFO and compares the FIFO's occupancy flags (same edge) and
// its registered status and read data (one edge later) against the model.
// It counts passing and failing checked cycles and records which fields failed.
module fifo_checker #(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             chk_en,
  input  logic                             clr_stats,
  input  logic                             wr_en,
  input  logic                             rd_en,
  input  logic [FIFO_WIDTH-1:0]            data_in,
  input  logic [FIFO_WIDTH-1:0]            data_out,
  input  logic                             wr_ack,
  input  logic                             overflow,
  input  logic                             underflow,
  input  logic                             full,
  input  logic                             empty,
  input  logic                             almostfull,
  input  logic                             almostempty,
  output logic [CNT_WIDTH-1:0]             correct_count,
  output logic [CNT_WIDTH-1:0]             error_count,
  output logic [7:0]                       err_sticky,
  output logic                             mismatch,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]  model_count
);

  localparam int MW = $clog2(FIFO_DEPTH+1);
  localparam int PW = $clog2(FIFO_DEPTH);

  // expectations captured at one edge, checked at the next
  typedef struct packed {
    logic                  ack;
    logic                  ovf;
    logic                  udf;
    logic                  rd;
    logic [FIFO_WIDTH-1:0] data;
  } pend_t;

  logic [FIFO_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wp, rp;
  logic [MW-1:0]         cnt;
  logic                  m_full, m_empty, m_afull, m_aempty;
  logic                  wr_acc, rd_acc;
  logic                  pend_vld;
  pend_t                 pend;
  logic [7:0]            fld_err;
  logic                  chk_fail;

  assign m_full   = (cnt == MW'(FIFO_DEPTH));
  assign m_empty  = (cnt == '0);
  assign m_afull  = (cnt == MW'(FIFO_DEPTH-1));
  assign m_aempty = (cnt == MW'(1));

  // full blocks writes and empty blocks reads, which also resolves the
  // simultaneous-request corner cases without extra logic
  assign wr_acc = wr_en && !m_full;
  assign rd_acc = rd_en && !m_empty;

  assign model_count = cnt;

  // model storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (wr_acc) mem[wp] <= data_in;
  end

  // model pointers and occupancy, wrapping at FIFO_DEPTH-1 for any depth
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp  <= '0;
      rp  <= '0;
      cnt <= '0;
    end else begin
      if (wr_acc) wp <= (wp == PW'(FIFO_DEPTH-1)) ? '0 : wp + 1'b1;
      if (rd_acc) rp <= (rp == PW'(FIFO_DEPTH-1)) ? '0 : rp + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // capture expected registered status and read data for the next edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_vld <= 1'b0;
      pend     <= '0;
    end else begin
      pend_vld  <= 1'b1;
      pend.ack  <= wr_acc;
      pend.ovf  <= wr_en && m_full;
      pend.udf  <= rd_en && m_empty;
      pend.rd   <= rd_acc;
      pend.data <= rd_acc ? mem[rp] : pend.data;
    end
  end

  // per-field mismatch: flags vs pre-edge model, status vs last edge's capture
  always_comb begin
    fld_err    = '0;
    fld_err[4] = (full        != m_full);
    fld_err[5] = (empty       != m_empty);
    fld_err[6] = (almostfull  != m_afull);
    fld_err[7] = (almostempty != m_aempty);
    if (pend_vld) begin
      fld_err[0] = pend.rd && (data_out != pend.data);
      fld_err[1] = (wr_ack    != pend.ack);
      fld_err[2] = (overflow  != pend.ovf);
      fld_err[3] = (underflow != pend.udf);
    end
  end

  assign chk_fail = chk_en && (|fld_err);

  // statistics: one saturating increment per checked edge, clear wins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      correct_count <= '0;
      error_count   <= '0;
      err_sticky    <= '0;
    end else if (clr_stats) begin
      correct_count <= '0;
      error_count   <= '0;
      err_sticky    <= '0;
    end else if (chk_en) begin
      err_sticky <= err_sticky | fld_err;
      if (|fld_err) begin
        if (~&error_count) error_count <= error_count + 1'b1;
      end else begin
        if (~&correct_count) correct_count <= correct_count + 1'b1;
      end
    end
  end

  // one-cycle pulse following any failing checked edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) mismatch <= 1'b0;
    else        mismatch <= chk_fail;
  end

endmodule

// File: tb/tb_fifo_checker.sv
// tb_fifo_checker: drives fifo_checker from a small behavioral FIFO with
// fault-injection knobs and checks the statistics against hand-computed values.
module tb_fifo_checker;

  localparam int W  = 16;
  localparam int D  = 8;
  localparam int CW = 6;  // small counters so saturation is reachable quickly

  logic          clk, rst_n, chk_en, clr_stats, wr_en, rd_en;
  logic [W-1:0]  data_in, data_out;
  logic          wr_ack, overflow, underflow, full, empty, almostfull, almostempty;
  logic [CW-1:0] correct_count, error_count;
  logic [7:0]    err_sticky;
  logic          mismatch;
  logic [3:0]    model_count;

  // fault-injection knobs for the stimulus FIFO
  logic inj_ovf_kill, inj_data_en, inj_full, inj_ack;

  int n_chk = 0;
  int n_err = 0;

  fifo_checker #(.FIFO_WIDTH(W), .FIFO_DEPTH(D), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst_n(rst_n), .chk_en(chk_en), .clr_stats(clr_stats),
    .wr_en(wr_en), .rd_en(rd_en), .data_in(data_in), .data_out(data_out),
    .wr_ack(wr_ack), .overflow(overflow), .underflow(underflow),
    .full(full), .empty(empty), .almostfull(almostfull), .almostempty(almostempty),
    .correct_count(correct_count), .error_count(error_count),
    .err_sticky(err_sticky), .mismatch(mismatch), .model_count(model_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // stimulus FIFO: a plain 8-deep FIFO with registered status
  logic [W-1:0] fmem [D];
  int           fwp, frp, fcnt;
  logic         ack_r, ovf_r, udf_r;
  logic [W-1:0] dout_r;
  logic         f_full, f_empty, f_wa, f_ra;

  assign f_full      = (fcnt == D);
  assign f_empty     = (fcnt == 0);
  assign f_wa        = wr_en && !f_full;
  assign f_ra        = rd_en && !f_empty;
  assign full        = f_full ^ inj_full;
  assign empty       = f_empty;
  assign almostfull  = (fcnt == D-1);
  assign almostempty = (fcnt == 1);
  assign wr_ack      = ack_r | inj_ack;
  assign overflow    = ovf_r;
  assign underflow   = udf_r;
  assign data_out    = dout_r;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fwp <= 0; frp <= 0; fcnt <= 0;
      ack_r <= 1'b0; ovf_r <= 1'b0; udf_r <= 1'b0; dout_r <= '0;
    end else begin
      ack_r <= f_wa;
      ovf_r <= wr_en && f_full && !inj_ovf_kill;
      udf_r <= rd_en && f_empty;
      if (f_wa) begin
        fmem[fwp] <= data_in;
        fwp <= (fwp + 1) % D;
      end
      if (f_ra) begin
        dout_r <= inj_data_en ? 16'h0009 : fmem[frp];
        frp <= (frp + 1) % D;
      end
      fcnt <= fcnt + int'(f_wa) - int'(f_ra);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [W-1:0] d;
    rst_n = 1'b0; chk_en = 1'b0; clr_stats = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
    data_in = '0; inj_ovf_kill = 1'b0; inj_data_en = 1'b0; inj_full = 1'b0; inj_ack = 1'b0;
    repeat (3) tick();
    chk("rst_correct", 32'(correct_count), 0);
    chk("rst_error",   32'(error_count),   0);
    chk("rst_sticky",  32'(err_sticky),    0);
    chk("rst_mm",      32'(mismatch),      0);
    chk("rst_mcnt",    32'(model_count),   0);

    // fill: 1 idle + 8 writes + 1 idle, all passing
    rst_n = 1'b1; chk_en = 1'b1;
    tick();
    for (int i = 0; i < 8; i++) begin
      wr_en = 1'b1; data_in = W'(i + 1);
      tick();
    end
    wr_en = 1'b0;
    tick();
    chk("fill_mcnt",    32'(model_count),   8);
    chk("fill_correct", 32'(correct_count), 10);
    chk("fill_error",   32'(error_count),   0);

    // write while full; FIFO fails to raise overflow
    inj_ovf_kill = 1'b1; wr_en = 1'b1; data_in = 16'h0009;
    tick();
    inj_ovf_kill = 1'b0; wr_en = 1'b0;
    tick();
    chk("ovf_error",   32'(error_count),   1);
    chk("ovf_correct", 32'(correct_count), 11);
    chk("ovf_sticky",  32'(err_sticky),    32'h04);
    chk("ovf_mm",      32'(mismatch),      1);
    chk("ovf_mcnt",    32'(model_count),   8);
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    chk("clr_mm",      32'(mismatch),      0);
    chk("clr_correct", 32'(correct_count), 0);
    chk("clr_sticky",  32'(err_sticky),    0);

    // drain 8; third read returns 0x0009 instead of 0x0003
    for (int i = 0; i < 8; i++) begin
      rd_en = 1'b1; inj_data_en = (i == 2);
      tick();
      if (i == 3) chk("rd_mm", 32'(mismatch), 1);
    end
    rd_en = 1'b0; inj_data_en = 1'b0;
    tick();
    chk("rd_error",   32'(error_count),   1);
    chk("rd_correct", 32'(correct_count), 8);
    chk("rd_sticky",  32'(err_sticky),    32'h01);
    chk("rd_mcnt",    32'(model_count),   0);

    // simultaneous requests at empty, full, and mid-level with pointer wrap
    clr_stats = 1'b1; tick(); clr_stats = 1'b0;
    d = 16'h0100;
    wr_en = 1'b1; rd_en = 1'b1; data_in = d; d++;
    tick();
    chk("sim_empty_mcnt", 32'(model_count), 1);
    rd_en = 1'b0;
    for (int i = 0; i < 7; i++) begin data_in = d; d++; tick(); end
    rd_en = 1'b1; data_in = 16'hdead;
    tick();
    chk("sim_full_mcnt", 32'(model_count), 7);
    wr_en = 1'b0;
    repeat (3) tick();
    wr_en = 1'b1;
    for (int i = 0; i < 6; i++) begin data_in = d; d++; tick(); end
    chk("sim_mid_mcnt", 32'(model_count), 4);
    wr_en = 1'b0;
    repeat (4) tick();
    rd_en = 1'b0;
    tick();
    chk("sim_mcnt",    32'(model_count),   0);
    chk("sim_error",   32'(error_count),   0);
    chk("sim_correct", 32'(correct_count), 23);
    chk("sim_sticky",  32'(err_sticky),    0);

    // chk_en low: model tracks, bad flag ignored
    clr_stats = 1'b1; tick(); clr_stats = 1'b0;
    chk_en = 1'b0; inj_full = 1'b1; wr_en = 1'b1; data_in = 16'h0aaa;
    repeat (2) tick();
    inj_full = 1'b0; wr_en = 1'b0;
    chk("dis_correct", 32'(correct_count), 0);
    chk("dis_error",   32'(error_count),   0);
    chk("dis_sticky",  32'(err_sticky),    0);
    chk("dis_mm",      32'(mismatch),      0);
    chk("dis_mcnt",    32'(model_count),   2);
    chk_en = 1'b1;
    tick();
    chk("en_correct", 32'(correct_count), 1);

    // saturation, then clear colliding with a failing check
    clr_stats = 1'b1; tick(); clr_stats = 1'b0;
    repeat (64) tick();
    chk("sat_correct", 32'(correct_count), 63);
    tick();
    chk("sat_hold", 32'(correct_count), 63);
    clr_stats = 1'b1; inj_full = 1'b1;
    tick();
    clr_stats = 1'b0; inj_full = 1'b0;
    chk("clrf_correct", 32'(correct_count), 0);
    chk("clrf_error",   32'(error_count),   0);
    chk("clrf_sticky",  32'(err_sticky),    0);

    // reset mid-burst at count 5
    wr_en = 1'b1; data_in = 16'h0bbb;
    repeat (3) tick();
    chk("pre_rst_mcnt",    32'(model_count),   5);
    chk("pre_rst_correct", 32'(correct_count), 3);
    rst_n = 1'b0;
    #1;
    chk("mrst_correct", 32'(correct_count), 0);
    chk("mrst_error",   32'(error_count),   0);
    chk("mrst_sticky",  32'(err_sticky),    0);
    chk("mrst_mm",      32'(mismatch),      0);
    chk("mrst_mcnt",    32'(model_count),   0);
    wr_en = 1'b0;
    tick();
    rst_n = 1'b1; inj_ack = 1'b1;
    tick();
    inj_ack = 1'b0;
    chk("post_rst_correct", 32'(correct_count), 1);
    chk("post_rst_error",   32'(error_count),   0);
    chk("post_rst_sticky",  32'(err_sticky),    0);
    tick();
    chk("post_rst2_correct", 32'(correct_count), 2);

    $display("[TB] %0d tests run, %0d failed", n_chk, n_err);
    $finish;
  end

endmodule
